// File: rtl/slot_reels.sv
// slot_reels : three-reel symbol generator for the slot-machine game.
//   A lever pulse spins all reels fast, then they decelerate and stop in
//   order (reel 1 first, reel 3 last), followed by a one-cycle done pulse.
//   Per-spin random offsets come from a free-running 16-bit LFSR.
// Ports:
//   clk        system clock
//   reset      synchronous active-high reset
//   start      lever pulse, sampled only in IDLE
//   force_win  (only with SLOT_REELS_FORCE_WIN_EN) latched on start; forces
//              reels 2 and 3 to stop on reel 1's symbol
//   c1..c3     reel symbols
//   busy       high in every state except IDLE
//   slowing    high in SLOW1/SLOW2/SLOW3
//   done       one-cycle pulse when reel 3 stops
// Optional feature macro: SLOT_REELS_FORCE_WIN_EN
module slot_reels #(
   parameter int NUM_SYM    = 6,
   parameter int SYM_W      = 3,
   parameter int FAST_DIV   = 2,
   parameter int SLOW_DIV   = 8,
   parameter int SPIN_STEPS = 12,
   parameter int SLOW_STEPS = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
`ifdef SLOT_REELS_FORCE_WIN_EN
   input  logic             force_win,
`endif
   output logic [SYM_W-1:0] c1,
   output logic [SYM_W-1:0] c2,
   output logic [SYM_W-1:0] c3,
   output logic             busy,
   output logic             slowing,
   output logic             done
);

   localparam int CW = 8;

   typedef enum logic [2:0] {IDLE, FAST, SLOW1, SLOW2, SLOW3, DONE} state_t;

   state_t           state, state_nx;
   logic [CW-1:0]    div, div_nx, cnt, cnt_nx, div_lim;
   logic [15:0]      lfsr;
   logic [SYM_W-1:0] r1, r2, r3;
   logic [SYM_W-1:0] c1_nx, c2_nx, c3_nx;
   logic             fw_q;
   logic             stepping, step;

   function automatic logic [SYM_W-1:0] inc(input logic [SYM_W-1:0] s);
      return (32'(s) == NUM_SYM - 1) ? '0 : s + 1'b1;
   endfunction

   // Fold a 3-bit LFSR slice into 0..NUM_SYM-1 with a single subtract.
   function automatic logic [SYM_W-1:0] red(input logic [2:0] v);
      return (32'(v) >= NUM_SYM) ? SYM_W'(32'(v) - NUM_SYM) : SYM_W'(v);
   endfunction

   always_comb begin
      stepping = (state == FAST) || (state == SLOW1) ||
                 (state == SLOW2) || (state == SLOW3);
      div_lim  = (state == FAST) ? CW'(FAST_DIV - 1) : CW'(SLOW_DIV - 1);
      step     = stepping && (div == div_lim);
      state_nx = state;
      div_nx   = stepping ? (step ? '0 : div + 1'b1) : '0;
      cnt_nx   = step ? cnt + 1'b1 : cnt;
      c1_nx    = c1;
      c2_nx    = c2;
      c3_nx    = c3;
      case (state)
         IDLE: begin
            if (start) begin
               state_nx = FAST;
               cnt_nx   = '0;
            end
         end
         FAST: begin
            if (step) begin
               c1_nx = inc(c1);
               c2_nx = inc(c2);
               c3_nx = inc(c3);
               if (cnt == CW'(SPIN_STEPS - 1)) begin
                  state_nx = SLOW1;
                  cnt_nx   = '0;
               end
            end
         end
         SLOW1: begin
            if (step) begin
               c1_nx = inc(c1);
               c2_nx = inc(c2);
               c3_nx = inc(c3);
               if (cnt == CW'(SLOW_STEPS - 1) + CW'(r1)) begin
                  state_nx = SLOW2;
                  cnt_nx   = '0;
               end
            end
         end
         SLOW2: begin
            // Past the base count, a forced win keeps stepping until the
            // reel lands on reel 1's symbol.
            if (step) begin
               c2_nx = inc(c2);
               c3_nx = inc(c3);
               if ((cnt >= CW'(SLOW_STEPS - 1) + CW'(r2)) &&
                   (!fw_q || inc(c2) == c1)) begin
                  state_nx = SLOW3;
                  cnt_nx   = '0;
               end
            end
         end
         SLOW3: begin
            if (step) begin
               c3_nx = inc(c3);
               if ((cnt >= CW'(SLOW_STEPS - 1) + CW'(r3)) &&
                   (!fw_q || inc(c3) == c1)) begin
                  state_nx = DONE;
                  cnt_nx   = '0;
               end
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         div   <= '0;
         cnt   <= '0;
         c1    <= '0;
         c2    <= '0;
         c3    <= '0;
         r1    <= '0;
         r2    <= '0;
         r3    <= '0;
         lfsr  <= 16'hACE1;
      end else begin
         state <= state_nx;
         div   <= div_nx;
         cnt   <= cnt_nx;
         c1    <= c1_nx;
         c2    <= c2_nx;
         c3    <= c3_nx;
         // Taps 16,14,13,11; feedback enters bit 0.
         lfsr  <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
         if (state == IDLE && start) begin
            r1 <= red(lfsr[2:0]);
            r2 <= red(lfsr[6:4]);
            r3 <= red(lfsr[10:8]);
         end
      end
   end

`ifdef SLOT_REELS_FORCE_WIN_EN
   always_ff @(posedge clk) begin
      if (reset)                        fw_q <= 1'b0;
      else if (state == IDLE && start)  fw_q <= force_win;
   end
`else
   assign fw_q = 1'b0;
`endif

   assign busy    = (state != IDLE);
   assign slowing = (state == SLOW1) || (state == SLOW2) || (state == SLOW3);
   assign done    = (state == DONE);

endmodule

// File: tb/tb_slot_reels.sv
// tb_slot_reels : directed self-checking bench for slot_reels.
//   Keeps an independent LFSR model to predict offsets, checks done timing,
//   final symbols, status flags, symbol range/wrap and reset behaviour.
module tb_slot_reels;

   logic       clk = 1'b0;
   logic       reset, start, fwin;
   logic [2:0] c1, c2, c3;
   logic       busy, slowing, done;
   logic [15:0] m_lfsr;
   int n_chk = 0, n_fail = 0, wraps = 0;

   always #5 clk = ~clk;

   slot_reels dut (
      .clk(clk), .reset(reset), .start(start),
`ifdef SLOT_REELS_FORCE_WIN_EN
      .force_win(fwin),
`endif
      .c1(c1), .c2(c2), .c3(c3),
      .busy(busy), .slowing(slowing), .done(done)
   );

   always @(posedge clk)
      m_lfsr <= reset ? 16'hACE1
                      : {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int red(input logic [2:0] v);
      return (v >= 6) ? int'(v) - 6 : int'(v);
   endfunction

   // Called at the negedge before the accepting posedge, start already high.
   task automatic track(input string tag, input int s1, input int s2, input int s3,
                        input logic [15:0] lv, input bit hold, input bit fw);
      int r1, r2, r3, nd, e1, e2, e3, n, errs, p1, p2, p3;
      bit got;
      r1 = red(lv[2:0]); r2 = red(lv[6:4]); r3 = red(lv[10:8]);
      nd = 24 + 8 * (9 + r1 + r2 + r3);
      e1 = (s1 + 15 + r1) % 6;
      e2 = (s2 + 18 + r1 + r2) % 6;
      e3 = (s3 + 21 + r1 + r2 + r3) % 6;
      n = 0; errs = 0; got = 0;
      p1 = s1; p2 = s2; p3 = s3;
      while (!got && n < 400) begin
         @(negedge clk);
         n++;
         if (!hold) start = 1'b0;
         if (busy !== 1'b1) errs++;
         if (slowing !== (n > 24 && !done)) errs++;
         if (c1 >= 6 || c2 >= 6 || c3 >= 6) errs++;
         if (p1 == 5 && c1 != 5) begin wraps++; if (c1 != 0) errs++; end
         if (p2 == 5 && c2 != 5) begin wraps++; if (c2 != 0) errs++; end
         if (p3 == 5 && c3 != 5) begin wraps++; if (c3 != 0) errs++; end
         p1 = c1; p2 = c2; p3 = c3;
         if (n >= 25 + 8 * (3 + r1) && c1 != e1) errs++;
         if (!fw && n >= 25 + 8 * (6 + r1 + r2) && c2 != e2) errs++;
         if (done) got = 1;
      end
      chk({tag, " done_seen"}, 32'(got), 1);
      chk({tag, " c1"}, 32'(c1), 32'(e1));
      if (!fw) begin
         chk({tag, " done_time"}, 32'(n), 32'(nd + 1));
         chk({tag, " c2"}, 32'(c2), 32'(e2));
         chk({tag, " c3"}, 32'(c3), 32'(e3));
      end else begin
         chk({tag, " win_c2"}, 32'(c2), 32'(c1));
         chk({tag, " win_c3"}, 32'(c3), 32'(c1));
      end
      chk({tag, " flags"}, 32'(errs), 0);
   endtask

   task automatic spin(input string tag, input bit fw);
      @(negedge clk);
      chk({tag, " idle"}, 32'(busy), 0);
      start = 1'b1;
      fwin  = fw;
      track(tag, int'(c1), int'(c2), int'(c3), m_lfsr, 1'b0, fw);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; fwin = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst c1", 32'(c1), 0);
      chk("rst c2", 32'(c2), 0);
      chk("rst c3", 32'(c3), 0);
      chk("rst busy", 32'(busy), 0);
      chk("rst slowing", 32'(slowing), 0);
      chk("rst done", 32'(done), 0);
      chk("rst lfsr", 32'(dut.lfsr), 32'h0000ACE1);
      reset = 1'b0;

      spin("nominal", 1'b0);

      // Start held high across a whole spin: one done, then a fresh spin.
      @(negedge clk);
      start = 1'b1;
      track("hold1", int'(c1), int'(c2), int'(c3), m_lfsr, 1'b1, 1'b0);
      @(negedge clk);
      chk("hold idle busy", 32'(busy), 0);
      chk("hold idle done", 32'(done), 0);
      track("hold2", int'(c1), int'(c2), int'(c3), m_lfsr, 1'b0, 1'b0);

      // Reset in the middle of FAST.
      @(negedge clk);
      start = 1'b1;
      repeat (10) begin @(negedge clk); start = 1'b0; end
      chk("midfast busy", 32'(busy), 1);
      reset = 1'b1;
      @(negedge clk);
      chk("midrst c1", 32'(c1), 0);
      chk("midrst c2", 32'(c2), 0);
      chk("midrst c3", 32'(c3), 0);
      chk("midrst busy", 32'(busy), 0);
      chk("midrst done", 32'(done), 0);
      repeat (2) @(negedge clk);
      chk("midrst lfsr", 32'(dut.lfsr), 32'h0000ACE1);
      reset = 1'b0;

      for (int i = 0; i < 50; i++) spin($sformatf("rnd%0d", i), 1'b0);
      chk("wraps seen", 32'(wraps > 0), 1);

`ifdef SLOT_REELS_FORCE_WIN_EN
      for (int i = 0; i < 20; i++) spin($sformatf("win%0d", i), 1'b1);
      spin("nowin", 1'b0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
